// File: rtl/sigma_delta_pkg.sv
// sigma_delta_pkg: shared types and constants for the sigma-delta DAC slice.
// The LFSR constants are only used when SIGMA_DELTA_DITHER_EN is defined.
package sigma_delta_pkg;

  // Soft mute / ramp controller states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_e;

  // Dither LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sigma_delta_gain_ramp.sv
// sigma_delta_gain_ramp: soft mute/ramp FSM and gain register.
// The gain moves only on sample_clk_ce; state follows enable on every clk.
module sigma_delta_gain_ramp
  import sigma_delta_pkg::*;
#(
  parameter int GAIN_WIDTH = 8,
  parameter int RAMP_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  sample_clk_ce,
  input  logic                  enable,
  output logic [GAIN_WIDTH-1:0] gain,
  output ramp_state_e           state,
  output logic                  muted,
  output logic                  running
);

  localparam logic [GAIN_WIDTH-1:0] GAIN_FULL = {GAIN_WIDTH{1'b1}};
  localparam logic [GAIN_WIDTH-1:0] STEP_G    = GAIN_WIDTH'(RAMP_STEP);

  ramp_state_e           state_q, state_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic [GAIN_WIDTH:0]   gain_up;
  logic [GAIN_WIDTH-1:0] gain_dn;

  // Next state from enable first, then the ce gain step belongs to that new state
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    gain_up = {1'b0, gain_q} + {1'b0, STEP_G};
    gain_dn = gain_q - STEP_G;
    case (state_q)
      IDLE:      if (enable)  state_d = RAMP_UP;
      RAMP_UP:   if (!enable) state_d = RAMP_DOWN;
      RUN:       if (!enable) state_d = RAMP_DOWN;
      RAMP_DOWN: if (enable)  state_d = RAMP_UP;
      default:   state_d = IDLE;
    endcase
    if (sample_clk_ce) begin
      case (state_d)
        RAMP_UP: begin
          if (gain_up >= {1'b0, GAIN_FULL}) begin
            gain_d  = GAIN_FULL;
            state_d = RUN;
          end else begin
            gain_d = gain_up[GAIN_WIDTH-1:0];
          end
        end
        RAMP_DOWN: begin
          if (gain_q <= STEP_G) begin
            gain_d  = '0;
            state_d = IDLE;
          end else begin
            gain_d = gain_dn;
          end
        end
        default: ;
      endcase
    end
  end

  // State and gain registers
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= IDLE;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  assign gain    = gain_q;
  assign state   = state_q;
  assign muted   = (state_q == IDLE);
  assign running = (state_q == RUN);

endmodule

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: first-order sigma-delta DAC with soft mute/ramp.
// Pipeline: sample register -> gain scaling -> offset-binary accumulator.
// Optional dither: define SIGMA_DELTA_DITHER_EN to add LFSR noise to u.
module sigma_delta_dac
  import sigma_delta_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 8,
  parameter int RAMP_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  sample_clk_ce,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  dac_out,
  output logic                  muted,
  output logic                  running
);

  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;

  logic [GAIN_WIDTH-1:0] gain;
  ramp_state_e           state;

  logic [DATA_WIDTH-1:0]    sample_q, sample_d;
  logic [DATA_WIDTH-1:0]    x_q, x_d;
  logic [DATA_WIDTH-1:0]    acc_q, acc_d;
  logic                     dac_q, dac_d;
  logic signed [PROD_W-1:0] product;
  logic [DATA_WIDTH-1:0]    u;
  logic [DATA_WIDTH:0]      sum;
`ifdef SIGMA_DELTA_DITHER_EN
  logic [15:0]              lfsr_q, lfsr_d;
`endif

  sigma_delta_gain_ramp #(
    .GAIN_WIDTH (GAIN_WIDTH),
    .RAMP_STEP  (RAMP_STEP)
  ) u_ramp (
    .clk           (clk),
    .arst          (arst),
    .sample_clk_ce (sample_clk_ce),
    .enable        (enable),
    .gain          (gain),
    .state         (state),
    .muted         (muted),
    .running       (running)
  );

  // Sample capture, gain scaling (floor shift) and the offset-binary modulator sum
  always_comb begin
    sample_d = sample_clk_ce ? sample_in : sample_q;
    product  = PROD_W'($signed(sample_q)) * PROD_W'($signed({1'b0, gain}));
    case (state)
      IDLE:    x_d = '0;
      RUN:     x_d = sample_q;
      default: x_d = DATA_WIDTH'(product >>> GAIN_WIDTH);
    endcase
    u = {~x_q[DATA_WIDTH-1], x_q[DATA_WIDTH-2:0]};
`ifdef SIGMA_DELTA_DITHER_EN
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    sum    = {1'b0, acc_q} + {1'b0, u} + (DATA_WIDTH+1)'(lfsr_q[1:0]);
`else
    sum    = {1'b0, acc_q} + {1'b0, u};
`endif
    acc_d = sum[DATA_WIDTH-1:0];
    dac_d = sum[DATA_WIDTH];
  end

  // Datapath registers; the accumulator wraps freely and its carry is the output bit
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sample_q <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      dac_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      dac_q    <= dac_d;
    end
  end

`ifdef SIGMA_DELTA_DITHER_EN
  // Free-running dither LFSR
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  assign dac_out = dac_q;

endmodule

// File: tb/tb_sigma_delta_dac.sv
// tb_sigma_delta_dac: self-checking bench for sigma_delta_dac (default build, no dither).
module tb_sigma_delta_dac;

  localparam int STEP = 1;
  localparam int GMAX = 255;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        sample_clk_ce = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample_in = '0;
  logic        dac_out;
  logic        muted;
  logic        running;

  int checks = 0;
  int errors = 0;

  sigma_delta_dac #(
    .DATA_WIDTH (16),
    .GAIN_WIDTH (8),
    .RAMP_STEP  (STEP)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .sample_clk_ce (sample_clk_ce),
    .enable        (enable),
    .sample_in     (sample_in),
    .dac_out       (dac_out),
    .muted         (muted),
    .running       (running)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Reference model state, plain integers
  typedef enum int {M_IDLE, M_UP, M_RUN, M_DOWN} mode_e;
  mode_e m_mode;
  int    m_gain;
  int    m_smp;
  int    m_x;
  int    m_acc;
  int    m_dac;

  typedef struct {
    int en;          // 0, 1, or 2 = random each cycle
    int ce;          // 0, 1, or 2 = random each cycle
    int cycles;
    int exp_gain;    // -1 = not checked
    int exp_muted;
    int exp_running;
  } row_t;
  row_t rows[14];

  task automatic resetModel();
    m_mode = M_IDLE;
    m_gain = 0;
    m_smp  = 0;
    m_x    = 0;
    m_acc  = 0;
    m_dac  = 0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  // One clock edge of the model: density modulator, scaling, sample capture, ramp rules
  task automatic modelEdge(input logic en, input logic ce, input logic [15:0] smp);
    int sum;
    int prod;
    sum   = m_acc + m_x + 32768;
    m_dac = (sum >= 65536) ? 1 : 0;
    m_acc = sum % 65536;
    case (m_mode)
      M_IDLE:  m_x = 0;
      M_RUN:   m_x = m_smp;
      default: begin
        prod = m_smp * m_gain;
        m_x  = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
      end
    endcase
    if (ce) m_smp = int'($signed(smp));
    if (m_mode == M_IDLE && en) m_mode = M_UP;
    else if ((m_mode == M_UP || m_mode == M_RUN) && !en) m_mode = M_DOWN;
    else if (m_mode == M_DOWN && en) m_mode = M_UP;
    if (ce) begin
      if (m_mode == M_UP) begin
        m_gain = (m_gain + STEP > GMAX) ? GMAX : m_gain + STEP;
        if (m_gain == GMAX) m_mode = M_RUN;
      end else if (m_mode == M_DOWN) begin
        m_gain = (m_gain - STEP < 0) ? 0 : m_gain - STEP;
        if (m_gain == 0) m_mode = M_IDLE;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " dac_out"}, 32'(dac_out), 32'(m_dac));
    checkVal({tag, " muted"}, 32'(muted), (m_mode == M_IDLE) ? 32'd1 : 32'd0);
    checkVal({tag, " running"}, 32'(running), (m_mode == M_RUN) ? 32'd1 : 32'd0);
    checkVal({tag, " gain"}, 32'(dut.gain), 32'(m_gain));
  endtask

  task automatic applyStimulus(input logic en, input logic ce, input logic [15:0] smp, input string tag);
    enable        = en;
    sample_clk_ce = ce;
    sample_in     = smp;
    @(posedge clk);
    modelEdge(en, ce, smp);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int ones;
    int acc_before;
    logic saw_one;

    rows[0]  = '{0, 1, 20,  0,   1, 0};
    rows[1]  = '{1, 0, 5,   0,   0, 0};
    rows[2]  = '{1, 1, 100, 100, 0, 0};
    rows[3]  = '{0, 1, 1,   99,  0, 0};
    rows[4]  = '{0, 1, 99,  0,   1, 0};
    rows[5]  = '{1, 1, 254, 254, 0, 0};
    rows[6]  = '{1, 1, 1,   255, 0, 1};
    rows[7]  = '{0, 1, 205, 50,  0, 0};
    rows[8]  = '{1, 1, 1,   51,  0, 0};
    rows[9]  = '{1, 1, 204, 255, 0, 1};
    rows[10] = '{1, 2, 300, 255, 0, 1};
    rows[11] = '{0, 1, 300, 0,   1, 0};
    rows[12] = '{2, 2, 400, -1, -1, -1};
    rows[13] = '{0, 1, 300, 0,   1, 0};

    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset");
    arst = 1'b1;

    // Idle after reset: x=0 gives u=0x8000, so the output alternates from the first update
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 16'($urandom_range(0, 65535)), "idle_alt");
      checkVal($sformatf("idle_alt_pattern[%0d]", i), 32'(dac_out), 32'(i % 2));
    end

    // Table of ramp phases with random samples
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < rows[r].cycles; c++) begin
        logic en_b;
        logic ce_b;
        en_b = (rows[r].en == 2) ? 1'($urandom_range(0, 1)) : 1'(rows[r].en);
        ce_b = (rows[r].ce == 2) ? 1'($urandom_range(0, 1)) : 1'(rows[r].ce);
        applyStimulus(en_b, ce_b, 16'($urandom_range(0, 65535)), $sformatf("row%0d", r));
      end
      if (rows[r].exp_gain >= 0) begin
        checkVal($sformatf("row%0d end_gain", r), 32'(dut.gain), 32'(rows[r].exp_gain));
        checkVal($sformatf("row%0d end_muted", r), 32'(muted), 32'(rows[r].exp_muted));
        checkVal($sformatf("row%0d end_running", r), 32'(running), 32'(rows[r].exp_running));
      end
    end

    // Reach RUN, then most-negative sample must give a constant 0
    for (int i = 0; i < 255; i++) applyStimulus(1'b1, 1'b1, 16'($urandom_range(0, 65535)), "to_run");
    checkVal("to_run running", 32'(running), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h8000, "neg_fill");
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, 1'b0, 16'($urandom_range(0, 65535)), "neg_hold");
      ones += int'(dac_out);
    end
    checkVal("min_sample_ones", 32'(ones), 32'd0);

    // 0x4000 in RUN: three ones in every four cycles
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h4000, "q_fill");
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 16'($urandom_range(0, 65535)), "q_hold");
      ones += int'(dac_out);
    end
    checks++;
    if (ones < 47 || ones > 49) begin
      errors++;
      $display("[TB] FAIL density_3_4 ones=%0d expected=48+-1 t=%0t", ones, $time);
    end

    // Single ce pulse of 0x7FFF after a silent (u=0) stretch
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h8000, "lat_fill");
    acc_before = m_acc;
    applyStimulus(1'b1, 1'b1, 16'h7FFF, "lat_e0");
    checkVal("lat_e0 dac", 32'(dac_out), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, "lat_e1");
    checkVal("lat_e1 dac", 32'(dac_out), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0000, "lat_e2");
    checkVal("lat_e2 dac", 32'(dac_out), (acc_before != 0) ? 32'd1 : 32'd0);
    saw_one = dac_out;
    applyStimulus(1'b1, 1'b0, 16'h0000, "lat_e3");
    saw_one = saw_one | dac_out;
    checkVal("lat_one_by_e3", 32'(saw_one), 32'd1);

    // Asynchronous reset in the middle of a ramp-up
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 16'($urandom_range(0, 65535)), "to_idle");
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 16'($urandom_range(0, 65535)), "ramp30");
    checkVal("ramp30 gain", 32'(dut.gain), 32'd30);
    #2;
    arst = 1'b0;
    #1;
    checkVal("async_rst dac_out", 32'(dac_out), 32'd0);
    checkVal("async_rst muted", 32'(muted), 32'd1);
    checkVal("async_rst running", 32'(running), 32'd0);
    checkVal("async_rst gain", 32'(dut.gain), 32'd0);
    resetModel();
    @(posedge clk);
    #1;
    checkOutput("rst_held");
    arst = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 16'($urandom_range(0, 65535)), "restart");
    checkVal("restart gain", 32'(dut.gain), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
